// File: rtl/uart_pkg.sv
// Shared definitions for the parity-capable UART transmitter:
// FSM state encoding, parity-mode encodings and parity helpers.
package uart_pkg;

    // Widest data word any transmitter instance may be configured for.
    localparam int MAX_DBIT = 9;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Raw parity-select encodings as they appear on par_mode.
    localparam logic [1:0] PAR_ENC_NONE = 2'b00;
    localparam logic [1:0] PAR_ENC_EVEN = 2'b01;
    localparam logic [1:0] PAR_ENC_ODD  = 2'b10;
    localparam logic [1:0] PAR_ENC_RSVD = 2'b11;

    // Parity mode; the reserved code behaves exactly like "none".
    typedef enum logic [1:0] {
        PAR_NONE = PAR_ENC_NONE,
        PAR_EVEN = PAR_ENC_EVEN,
        PAR_ODD  = PAR_ENC_ODD,
        PAR_RSVD = PAR_ENC_RSVD
    } par_mode_e;

    // True when the frame carries a parity bit.
    function automatic logic parity_enabled(input par_mode_e mode);
        logic en;
        case (mode)
            PAR_EVEN: en = 1'b1;
            PAR_ODD:  en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // Parity bit for a zero-extended data word. Unused upper bits are zero
    // so they do not disturb the XOR reduction. For modes without parity
    // the line idle level is returned.
    function automatic logic parity_bit(input logic [MAX_DBIT-1:0] data,
                                        input par_mode_e           mode);
        logic x;
        logic p;
        x = ^data;
        case (mode)
            PAR_EVEN: p = x;
            PAR_ODD:  p = ~x;
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_par_chk.sv
// Protocol checker for uart_tx_par outputs; bound or instantiated alongside
// the transmitter, never inside it.
module uart_tx_par_chk (
    input logic clk,
    input logic rst,
    input logic tx,
    input logic tx_done,
    input logic busy
);

    // The done pulse coincides with busy falling.
    a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
        tx_done |-> !busy)
        else $error("uart_tx_par_chk: tx_done while busy");

    // The done pulse is exactly one clock wide.
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        tx_done |=> !tx_done)
        else $error("uart_tx_par_chk: tx_done wider than one clock");

    // An idle transmitter holds the line high.
    a_idle_high: assert property (@(posedge clk) disable iff (rst)
        !busy |-> tx)
        else $error("uart_tx_par_chk: line low while idle");

endmodule

// File: rtl/uart_tx_par.sv
// UART transmitter with optional even/odd parity. Frames are paced by an
// external oversampling tick (s_tick); every start, data and parity bit
// lasts OVS ticks and the stop period lasts SB_TICK ticks. All outputs
// come straight from flops so the serial line cannot glitch.
module uart_tx_par #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    input  logic [1:0]      par_mode,
    output logic            tx,
    output logic            tx_done,
    output logic            busy
);

    import uart_pkg::*;

    // Tick counter must hold the larger of the bit and stop periods minus one.
    localparam int TICK_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] OVS_LAST  = TW'(OVS - 1);
    localparam logic [TW-1:0] SB_LAST   = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    // Registered state
    tx_state_e       state_r;
    logic [TW-1:0]   tick_r;
    logic [BW-1:0]   bit_r;
    logic [DBIT-1:0] data_r;
    par_mode_e       mode_r;
    logic            tx_r;
    logic            done_r;
    logic            busy_r;

    // Next-state values
    tx_state_e       state_s;
    logic [TW-1:0]   tick_s;
    logic [BW-1:0]   bit_s;
    logic [DBIT-1:0] data_s;
    par_mode_e       mode_s;
    logic            done_s;
    logic            tx_s;
    logic            busy_s;

    // Helpers for output decode
    logic [DBIT-1:0]     data_shift_s;
    logic [MAX_DBIT-1:0] data_ext_s;

    // Next-state logic: frame sequencing, tick/bit counting and request latching.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        bit_s   = bit_r;
        data_s  = data_r;
        mode_s  = mode_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (tx_start) begin
                    state_s = ST_START;
                    tick_s  = TICK_ZERO;
                    bit_s   = BIT_ZERO;
                    data_s  = tx_din;
                    mode_s  = par_mode_e'(par_mode);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (tick_r == OVS_LAST) begin
                        state_s = ST_DATA;
                        tick_s  = TICK_ZERO;
                        bit_s   = BIT_ZERO;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (tick_r == OVS_LAST) begin
                        tick_s = TICK_ZERO;
                        if (bit_r == BIT_LAST) begin
                            bit_s   = BIT_ZERO;
                            state_s = parity_enabled(mode_r) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_s = bit_r + BIT_ONE;
                        end
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_r == OVS_LAST) begin
                        state_s = ST_STOP;
                        tick_s  = TICK_ZERO;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (tick_r == SB_LAST) begin
                        state_s = ST_IDLE;
                        tick_s  = TICK_ZERO;
                        done_s  = 1'b1;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                tick_s  = TICK_ZERO;
                bit_s   = BIT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so tx/busy can be registered without lag.
    always_comb begin
        data_shift_s         = data_s >> bit_s;
        data_ext_s           = '0;
        data_ext_s[DBIT-1:0] = data_s;
        busy_s               = (state_s != ST_IDLE);

        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = data_shift_s[0];
            ST_PARITY: tx_s = parity_bit(data_ext_s, mode_s);
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            data_r  <= '0;
            mode_r  <= PAR_NONE;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            mode_r  <= mode_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign tx      = tx_r;
    assign tx_done = done_r;
    assign busy    = busy_r;

endmodule

// File: doc/uart_tx_par.md
UART_TX_PAR -- requirements
Module: uart_tx_par

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter OVS, default 16, s_tick pulses per start, data or parity bit.
REQ-003 Parameter SB_TICK, default 16, s_tick pulses per stop period: 16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port s_tick, input, 1, oversampling enable pulse, one clk wide.
REQ-007 Port tx_start, input, 1, request to send tx_din.
REQ-008 Port tx_din, input, DBIT, data word, sent LSB first.
REQ-009 Port par_mode, input, 2, parity select: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 Port tx, output, 1, serial line, idle high.
REQ-011 Port tx_done, output, 1, one-clk pulse at frame end.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 tx_start SHALL be accepted only on a clk edge where state = IDLE; in all other states it is ignored.
REQ-015 On acceptance, tx_din and par_mode SHALL be latched; later changes to them do not affect the current frame.
REQ-016 On acceptance, the FSM SHALL enter START; tx = 0 and busy = 1 from the next cycle.
REQ-017 A tick counter SHALL advance only on s_tick; with no s_tick, state and tx hold indefinitely.
REQ-018 START SHALL last OVS ticks, then the FSM enters DATA with bit index 0.
REQ-019 DATA SHALL drive tx = latched data[bit index] for OVS ticks per bit.
REQ-020 After bit DBIT-1, the FSM SHALL go to PARITY if the latched mode is 01 or 10, otherwise to STOP.
REQ-021 PARITY SHALL drive, for OVS ticks, XOR of the data bits for even, or its inverse for odd.
REQ-022 STOP SHALL drive tx = 1 for SB_TICK ticks.
REQ-023 On the final stop tick, the FSM SHALL return to IDLE and pulse tx_done high for exactly one clk, in the same cycle busy falls.
REQ-024 The tick counter SHALL be wide enough for max(OVS, SB_TICK)-1 and wrap to 0 at each bit boundary.
REQ-025 The bit index SHALL be wide enough for DBIT-1.
REQ-026 The next frame SHALL be acceptable on the first cycle after tx_done.
REQ-027 tx SHALL be registered and glitch-free.

Reset
REQ-028 While rst = 1, outputs SHALL be tx = 1, tx_done = 0, busy = 0, and state SHALL be IDLE.
REQ-029 While rst = 1, all counters and latched data/mode SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no tx_done pulse.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, the parity-mode enum and the parity encodings.
REQ-032 The s_tick source SHALL be the team's separate uart_baud_gen.
REQ-033 No sub-module SHALL be instantiated inside uart_tx_par.

Verification
REQ-034 8N1 (DBIT=8, SB_TICK=16, mode 00), s_tick every clk, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clk; tx_done 160 clk after acceptance.
REQ-035 Mode 01 with 0x07 -> parity bit 1; mode 10 with 0x07 -> parity bit 0; frame 176 clk.
REQ-036 DBIT=7, SB_TICK=32, mode 00, send 0x55 -> 7 data bits, then tx high for 32 ticks; frame 160 ticks.
REQ-037 tx_start pulsed during DATA with new tx_din -> ignored; the frame in flight completes unchanged; busy stays 1.
REQ-038 rst asserted in DATA bit 3 -> tx = 1, busy = 0 immediately; no tx_done; next tx_start sends a full frame.
REQ-039 s_tick held low for 50 clk mid-START -> tx stays 0 and the frame resumes, with total tick count unchanged.
